// File: rtl/matrix_pkg.sv
// Shared geometry and frame types for the 16x16 LED matrix.
// Used by the scanner and by the bird/game logic that renders frames.
package matrix_pkg;

    localparam int ROWS  = 16;
    localparam int COLS  = 16;
    localparam int ROW_W = $clog2(ROWS);

    typedef logic [ROWS-1:0][COLS-1:0] frame_t;
    typedef logic [COLS-1:0]           col_t;
    typedef logic [ROWS-1:0]           rowsel_t;
    typedef logic [ROW_W-1:0]          row_idx_t;

    function automatic rowsel_t onehot_row(input row_idx_t idx);
        onehot_row = rowsel_t'(1) << idx;
    endfunction

endpackage

// File: rtl/matrix_scan.sv
// Row-multiplexed scanner for the 16x16 LED matrix with per-row blanking
// and a tear-free frame buffer refreshed once per frame.
module matrix_scan
    import matrix_pkg::*;
#(
    parameter int TICKS_PER_ROW = 1000,
    parameter int BLANK_TICKS   = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    en,
    input  frame_t  red,
    output rowsel_t row_en,
    output col_t    col,
    output logic    frame_done
);

    if (TICKS_PER_ROW < 2) begin : g_bad_ticks
        $error("matrix_scan: TICKS_PER_ROW must be >= 2");
    end

    if (BLANK_TICKS < 0 || BLANK_TICKS >= TICKS_PER_ROW) begin : g_bad_blank
        $error("matrix_scan: BLANK_TICKS must be in 0..TICKS_PER_ROW-1");
    end

    localparam int TW = (TICKS_PER_ROW > 2) ? $clog2(TICKS_PER_ROW) : 1;

    localparam logic [TW-1:0] LAST_TICK = TW'(TICKS_PER_ROW - 1);
    localparam logic [TW-1:0] BLANK_END = TW'(BLANK_TICKS);
    localparam row_idx_t      LAST_ROW  = row_idx_t'(ROWS - 1);
    localparam logic          HAS_BLANK = (BLANK_TICKS > 0);

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } state_e;

    state_e        r_state;
    state_e        w_state_nxt;
    logic [TW-1:0] r_tick;
    logic [TW-1:0] w_tick_nxt;
    row_idx_t      r_row;
    row_idx_t      w_row_nxt;
    frame_t        r_buf;
    frame_t        w_buf_nxt;
    rowsel_t       r_row_en;
    rowsel_t       w_row_en_nxt;
    col_t          r_col;
    logic          r_frame_done;
    logic          w_fd_nxt;
    logic          w_row_end;
    logic          w_snap;

    assign w_row_end = (r_tick == LAST_TICK);
    assign w_snap    = en && w_row_end && (r_row == LAST_ROW);

    // Outputs are registered from the post-edge state so that row_en/col
    // line up with the tick the scanner is actually in.
    always_comb begin
        w_state_nxt  = r_state;
        w_tick_nxt   = r_tick;
        w_row_nxt    = r_row;
        w_buf_nxt    = r_buf;
        w_row_en_nxt = '0;
        w_fd_nxt     = 1'b0;

        if (en) begin
            if (w_row_end) begin
                w_tick_nxt  = '0;
                w_row_nxt   = r_row + 1'b1;
                w_state_nxt = HAS_BLANK ? ST_BLANK : ST_DRIVE;
            end else begin
                w_tick_nxt = r_tick + 1'b1;
                unique case (r_state)
                    ST_BLANK: begin
                        if (!HAS_BLANK || w_tick_nxt == BLANK_END) begin
                            w_state_nxt = ST_DRIVE;
                        end
                    end
                    ST_DRIVE: w_state_nxt = ST_DRIVE;
                    default:  w_state_nxt = ST_BLANK;
                endcase
            end

            if (w_snap) begin
                w_buf_nxt = red;
            end

            if (w_state_nxt == ST_DRIVE) begin
                w_row_en_nxt = onehot_row(w_row_nxt);
            end

            w_fd_nxt = (w_tick_nxt == LAST_TICK) && (w_row_nxt == LAST_ROW);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_BLANK;
            r_tick       <= '0;
            r_row        <= '0;
            r_buf        <= '0;
            r_row_en     <= '0;
            r_col        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_tick       <= w_tick_nxt;
            r_row        <= w_row_nxt;
            r_buf        <= w_buf_nxt;
            r_row_en     <= w_row_en_nxt;
            r_col        <= w_buf_nxt[w_row_nxt];
            r_frame_done <= w_fd_nxt;
        end
    end

    assign row_en     = r_row_en;
    assign col        = r_col;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_matrix_scan.sv
// Directed + randomized bench for matrix_scan against a cycle-count model.
// The model tracks enabled cycles since reset and derives row/tick from it.
module tb_matrix_scan;
    import matrix_pkg::*;

    localparam int T     = 8;
    localparam int B     = 2;
    localparam int FRAME = 16 * T;

    logic    clk = 1'b0;
    logic    rst;
    logic    en;
    frame_t  red;
    rowsel_t row_en;
    col_t    col;
    logic    frame_done;

    int      vectors = 0;
    int      miscompares = 0;
    int      cyc = 0;
    int      n = 0;
    frame_t  mbuf = '0;
    bit      gate = 1'b0;
    logic    prev_fd = 1'b0;

    matrix_scan #(
        .TICKS_PER_ROW(T),
        .BLANK_TICKS  (B)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .red       (red),
        .row_en    (row_en),
        .col       (col),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h",
                   tag, cyc, obs, want);
        end
    endtask

    task automatic step();
        int      tick;
        int      row;
        logic [15:0] want_re;
        @(posedge clk);
        if (rst) begin
            n    = 0;
            mbuf = '0;
            gate = 1'b0;
            cyc  = 0;
        end else begin
            cyc++;
            if (en) begin
                if (n == FRAME - 1) mbuf = red;
                n    = (n + 1) % FRAME;
                gate = 1'b1;
            end else begin
                gate = 1'b0;
            end
        end
        @(negedge clk);
        tick    = n % T;
        row     = n / T;
        want_re = (gate && tick >= B) ? (16'(1) << row) : 16'h0;
        chk("row_en", row_en, want_re);
        chk("col", col, mbuf[row]);
        chk("frame_done", {15'b0, frame_done},
            {15'b0, (gate && n == FRAME - 1)});
        chk("onehot0", {15'b0, $onehot0(row_en)}, 16'h1);
        chk("fd_pair", {15'b0, prev_fd & frame_done}, 16'h0);
        prev_fd = frame_done;
    endtask

    task automatic rand_frame();
        for (int r = 0; r < 16; r++) red[r] = 16'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        red = '0;
        step();
        step();
        chk("rst_row_en", row_en, 16'h0);
        chk("rst_col", col, 16'h0);
        rst = 1'b0;
        red[0]  = 16'hA5A5;
        red[15] = 16'h8001;

        while (cyc < 300) begin
            step();
            if (cyc == 1)   chk("c1_row_en", row_en, 16'h0000);
            if (cyc == 2)   chk("c2_row_en", row_en, 16'h0001);
            if (cyc == 2)   chk("c2_col", col, 16'h0000);
            if (cyc == 7)   chk("c7_row_en", row_en, 16'h0001);
            if (cyc == 8)   chk("c8_row_en", row_en, 16'h0000);
            if (cyc == 126) chk("c126_fd", {15'b0, frame_done}, 16'h0);
            if (cyc == 127) chk("c127_fd", {15'b0, frame_done}, 16'h1);
            if (cyc == 130) chk("c130_col", col, 16'hA5A5);
            if (cyc == 135) chk("c135_row_en", row_en, 16'h0001);
            if (cyc == 135) chk("c135_col", col, 16'hA5A5);
            if (cyc == 140) red[3] = 16'hFFFF;
            if (cyc == 154) chk("f2_row3_col", col, 16'h0000);
            if (cyc == 250) chk("f2_row15_col", col, 16'h8001);
            if (cyc == 250) chk("f2_row15_en", row_en, 16'h8000);
            if (cyc == 282) chk("f3_row3_col", col, 16'hFFFF);
        end

        chk("pre_freeze_en", row_en, 16'h0020);
        en = 1'b0;
        repeat (20) begin
            step();
            chk("freeze_row_en", row_en, 16'h0000);
        end
        en = 1'b1;
        while (cyc < 330) begin
            step();
            if (cyc == 321) chk("resume_t5", row_en, 16'h0020);
            if (cyc == 323) chk("resume_t7", row_en, 16'h0020);
            if (cyc == 324) chk("row6_blank", row_en, 16'h0000);
            if (cyc == 326) chk("row6_drive", row_en, 16'h0040);
        end

        while (cyc < 479) begin
            if (cyc % 8 == 0) rand_frame();
            step();
        end
        chk("pre_rst_row9", row_en, 16'h0200);

        rst = 1'b1;
        step();
        chk("midrst_row_en", row_en, 16'h0000);
        chk("midrst_col", col, 16'h0000);
        rst = 1'b0;
        while (cyc < 255) begin
            rand_frame();
            step();
            if (cyc < FRAME) chk("blank_frame_col", col, 16'h0000);
        end

        repeat (300) begin
            en = ($urandom_range(0, 3) != 0);
            if (cyc % 5 == 0) rand_frame();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
